// File: rtl/buff_arbiter.sv
// Round-robin arbiter sharing one buffer write port among NUM_REQ token requesters,
// with burst limiting, nack stall handling and a pass-through read enable.

package buff_arbiter_pkg;
  localparam int DATA_W = 8;

  typedef struct packed {
    logic              v;
    logic [DATA_W-1:0] d;
  } FTk_t;

  typedef struct packed {
    logic v;
    logic t;
    logic c;
    logic n;
  } BTk_t;
endpackage

// Backward token for one requester: the owner sees the buffer's token, everyone else is held off.
module buff_arb_btk
  import buff_arbiter_pkg::*;
(
  input  logic is_owner,
  input  logic in_grant,
  input  logic in_stall,
  input  logic acc,
  input  logic req_v,
  input  BTk_t i_btk,
  output BTk_t o_btk
);
  always_comb begin
    o_btk = '0;
    if (is_owner && (in_grant || in_stall)) begin
      o_btk   = i_btk;
      o_btk.n = in_stall ? 1'b1 : ~acc;
    end else begin
      o_btk.n = req_v;
    end
  end
endmodule

module buff_arbiter
  import buff_arbiter_pkg::*;
#(
  parameter  int NUM_REQ   = 4,
  parameter  int BURST_LEN = 8,
  localparam int WIDTH_REQ = $clog2(NUM_REQ),
  localparam int CNT_W     = $clog2(BURST_LEN) + 1
) (
  input  logic               clock,
  input  logic               reset,
  input  FTk_t               I_FTk [NUM_REQ],
  output BTk_t               O_BTk [NUM_REQ],
  output FTk_t               O_FTk,
  output logic               O_We,
  input  BTk_t               I_BTk,
  input  logic               I_Full,
  input  logic               I_Empty,
  input  logic               I_Rd_En,
  output logic               O_Re,
  output logic [NUM_REQ-1:0] O_Grant,
  output logic               O_Busy
);
  typedef enum logic [1:0] {IDLE, GRANT, STALL} state_t;

  state_t               state_q, state_d;
  logic [WIDTH_REQ-1:0] owner_q, owner_d;
  logic [WIDTH_REQ-1:0] ptr_q, ptr_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;

  logic [NUM_REQ-1:0]   req_vec;
  logic [WIDTH_REQ-1:0] sel, sel_hi, sel_lo, owner_nxt;
  logic                 found_hi, found_lo;
  FTk_t                 owner_ftk;
  logic                 acc;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_req
    assign req_vec[g] = I_FTk[g].v;
  end

  // First requester at or after the pointer; fall back to the lowest index (wrap).
  always_comb begin
    sel_hi   = '0;
    sel_lo   = '0;
    found_hi = 1'b0;
    found_lo = 1'b0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req_vec[i]) begin
        sel_lo   = WIDTH_REQ'(i);
        found_lo = 1'b1;
        if (i >= int'(ptr_q)) begin
          sel_hi   = WIDTH_REQ'(i);
          found_hi = 1'b1;
        end
      end
    end
    sel = found_hi ? sel_hi : sel_lo;
  end

  // Explicit wrap keeps owner+1 correct for non-power-of-2 NUM_REQ.
  assign owner_nxt = (owner_q == WIDTH_REQ'(NUM_REQ - 1)) ? '0 : owner_q + 1'b1;
  assign owner_ftk = I_FTk[owner_q];
  assign acc       = (state_q == GRANT) && owner_ftk.v && !I_BTk.n && !I_Full;

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    O_We    = 1'b0;
    O_FTk   = '0;
    case (state_q)
      IDLE: begin
        if (found_lo && !I_BTk.n && !I_Full) begin
          owner_d = sel;
          cnt_d   = '0;
          state_d = GRANT;
        end
      end
      GRANT: begin
        O_FTk = owner_ftk;
        O_We  = acc;
        cnt_d = cnt_q + CNT_W'(acc);
        if (I_BTk.n) begin
          state_d = STALL;
        end else if (!owner_ftk.v || (acc && cnt_q == CNT_W'(BURST_LEN - 1))) begin
          state_d = IDLE;
          ptr_d   = owner_nxt;
        end
      end
      STALL: begin
        if (!owner_ftk.v) begin
          state_d = IDLE;
          ptr_d   = owner_nxt;
        end else if (!I_BTk.n) begin
          state_d = GRANT;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      owner_q <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    O_Grant = '0;
    if (state_q != IDLE) O_Grant[owner_q] = 1'b1;
  end

  assign O_Busy = (state_q != IDLE);
  assign O_Re   = I_Rd_En & ~I_Empty;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_btk
    buff_arb_btk u_btk (
      .is_owner (owner_q == WIDTH_REQ'(g)),
      .in_grant (state_q == GRANT),
      .in_stall (state_q == STALL),
      .acc      (acc),
      .req_v    (I_FTk[g].v),
      .i_btk    (I_BTk),
      .o_btk    (O_BTk[g])
    );
  end
endmodule

// File: tb/tb_buff_arbiter.sv
// Directed bench for buff_arbiter: a 4-requester/burst-8 instance and a 3-requester/burst-1 instance.
module tb_buff_arbiter;
  import buff_arbiter_pkg::*;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  FTk_t ftk4 [4];
  BTk_t obtk4 [4];
  FTk_t oftk4;
  logic we4, re4, busy4;
  logic [3:0] gnt4;

  FTk_t ftk3 [3];
  BTk_t obtk3 [3];
  FTk_t oftk3;
  logic we3, re3, busy3;
  logic [2:0] gnt3;

  BTk_t ibtk;
  logic full, empty, rd_en;

  int checks = 0;
  int errors = 0;

  buff_arbiter #(.NUM_REQ(4), .BURST_LEN(8)) u_dut4 (
    .clock(clock), .reset(reset), .I_FTk(ftk4), .O_BTk(obtk4), .O_FTk(oftk4),
    .O_We(we4), .I_BTk(ibtk), .I_Full(full), .I_Empty(empty), .I_Rd_En(rd_en),
    .O_Re(re4), .O_Grant(gnt4), .O_Busy(busy4)
  );

  buff_arbiter #(.NUM_REQ(3), .BURST_LEN(1)) u_dut3 (
    .clock(clock), .reset(reset), .I_FTk(ftk3), .O_BTk(obtk3), .O_FTk(oftk3),
    .O_We(we3), .I_BTk(ibtk), .I_Full(full), .I_Empty(empty), .I_Rd_En(rd_en),
    .O_Re(re3), .O_Grant(gnt3), .O_Busy(busy3)
  );

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic clear_reqs;
    for (int i = 0; i < 4; i++) ftk4[i] = '0;
    for (int i = 0; i < 3; i++) ftk3[i] = '0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    ftk4[0] = '{v: 1'b1, d: 8'h77};
    tick; tick;
    #1;
    checks++; if (gnt4 !== 4'b0000) begin errors++; $display("FAIL rst_gnt got %b want 0000", gnt4); end
    checks++; if (busy4 !== 1'b0) begin errors++; $display("FAIL rst_busy got %b want 0", busy4); end
    checks++; if (we4 !== 1'b0) begin errors++; $display("FAIL rst_we got %b want 0", we4); end
    checks++; if (oftk4 !== FTk_t'(0)) begin errors++; $display("FAIL rst_oftk got %h want 0", oftk4); end
    checks++; if (gnt3 !== 3'b000) begin errors++; $display("FAIL rst_gnt3 got %b want 000", gnt3); end
    clear_reqs;
    reset = 1'b0;
    #1;
  endtask

  task automatic test_nack_idle;
    ftk4[1] = '{v: 1'b1, d: 8'h11};
    ibtk.n = 1'b1;
    for (int c = 0; c < 2; c++) begin
      #1;
      checks++; if (gnt4 !== 4'b0000) begin errors++; $display("FAIL nack_idle_gnt c%0d got %b want 0000", c, gnt4); end
      checks++; if (obtk4[1].n !== 1'b1) begin errors++; $display("FAIL nack_idle_n got %b want 1", obtk4[1].n); end
      tick;
    end
    ftk4[1] = '0;
    ibtk = '0;
    #1;
  endtask

  // Requesters 0 and 2 stream continuously; expect bursts 0,2,0 of 8 with a 1-cycle gap.
  task automatic test_alternate;
    int order [3] = '{0, 2, 0};
    logic [3:0] exp;
    ftk4[0] = '{v: 1'b1, d: 8'hA0};
    ftk4[2] = '{v: 1'b1, d: 8'hC2};
    for (int b = 0; b < 3; b++) begin
      #1;
      checks++; if (gnt4 !== 4'b0000 || we4 !== 1'b0) begin errors++; $display("FAIL alt_gap b%0d got gnt %b we %b want 0000 0", b, gnt4, we4); end
      checks++; if (oftk4 !== FTk_t'(0)) begin errors++; $display("FAIL alt_gap_oftk got %h want 0", oftk4); end
      tick;
      exp = 4'b0001 << order[b];
      for (int w = 0; w < 8; w++) begin
        #1;
        checks++; if (gnt4 !== exp || we4 !== 1'b1) begin errors++; $display("FAIL alt_burst b%0d w%0d got gnt %b we %b want %b 1", b, w, gnt4, we4, exp); end
        checks++; if (oftk4.d !== ftk4[order[b]].d) begin errors++; $display("FAIL alt_data got %h want %h", oftk4.d, ftk4[order[b]].d); end
        checks++; if (obtk4[order[b]].n !== 1'b0 || obtk4[2 - order[b]].n !== 1'b1) begin errors++; $display("FAIL alt_n own %b other %b want 0 1", obtk4[order[b]].n, obtk4[2 - order[b]].n); end
        tick;
      end
    end
  endtask

  // Pointer is 1 here; requester 1 writes 3 tokens then drops.
  task automatic test_drop;
    clear_reqs;
    ftk4[1] = '{v: 1'b1, d: 8'h11};
    #1;
    tick;
    for (int w = 0; w < 3; w++) begin
      #1;
      checks++; if (gnt4 !== 4'b0010 || we4 !== 1'b1) begin errors++; $display("FAIL drop_burst w%0d got gnt %b we %b want 0010 1", w, gnt4, we4); end
      tick;
    end
    ftk4[1].v = 1'b0;
    #1;
    checks++; if (we4 !== 1'b0) begin errors++; $display("FAIL drop_we got %b want 0", we4); end
    tick;
    #1;
    checks++; if (gnt4 !== 4'b0000) begin errors++; $display("FAIL drop_idle got %b want 0000", gnt4); end
    ftk4[1].v = 1'b1;
    ftk4[3] = '{v: 1'b1, d: 8'h33};
    #1;
    tick;
    #1;
    checks++; if (gnt4 !== 4'b1000) begin errors++; $display("FAIL drop_ptr got %b want 1000", gnt4); end
    clear_reqs;
    #1;
    checks++; if (we4 !== 1'b0) begin errors++; $display("FAIL drop3_we got %b want 0", we4); end
    tick;
    #1;
    checks++; if (busy4 !== 1'b0) begin errors++; $display("FAIL drop_busy got %b want 0", busy4); end
  endtask

  // 5 writes, 4 nack cycles, then 3 more writes to reach the limit of 8.
  task automatic test_stall;
    ftk4[0] = '{v: 1'b1, d: 8'hA0};
    #1;
    tick;
    for (int w = 0; w < 5; w++) begin
      #1;
      checks++; if (we4 !== 1'b1) begin errors++; $display("FAIL stall_pre w%0d got %b want 1", w, we4); end
      tick;
    end
    ibtk.n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      #1;
      checks++; if (we4 !== 1'b0 || obtk4[0].n !== 1'b1) begin errors++; $display("FAIL stall_nack c%0d got we %b n %b want 0 1", c, we4, obtk4[0].n); end
      checks++; if (gnt4 !== 4'b0001) begin errors++; $display("FAIL stall_gnt c%0d got %b want 0001", c, gnt4); end
      tick;
    end
    ibtk.n = 1'b0;
    #1;
    checks++; if (we4 !== 1'b0 || busy4 !== 1'b1 || obtk4[0].n !== 1'b1) begin errors++; $display("FAIL stall_exit got we %b busy %b n %b want 0 1 1", we4, busy4, obtk4[0].n); end
    tick;
    for (int w = 0; w < 3; w++) begin
      #1;
      checks++; if (we4 !== 1'b1) begin errors++; $display("FAIL stall_post w%0d got %b want 1", w, we4); end
      tick;
    end
    #1;
    checks++; if (gnt4 !== 4'b0000 || we4 !== 1'b0) begin errors++; $display("FAIL stall_end got gnt %b we %b want 0000 0", gnt4, we4); end
    clear_reqs;
    #1;
    tick;
  endtask

  task automatic test_full_copy;
    ftk4[0] = '{v: 1'b1, d: 8'h5A};
    #1;
    tick;
    full = 1'b1;
    ibtk = '{v: 1'b1, t: 1'b1, c: 1'b1, n: 1'b0};
    ftk4[2].v = 1'b1;
    #1;
    checks++; if (we4 !== 1'b0 || obtk4[0].n !== 1'b1) begin errors++; $display("FAIL full_we got we %b n %b want 0 1", we4, obtk4[0].n); end
    checks++; if (obtk4[0].t !== 1'b1 || obtk4[0].c !== 1'b1 || obtk4[0].v !== 1'b1) begin errors++; $display("FAIL own_copy got %b want 1111", obtk4[0]); end
    checks++; if (obtk4[2] !== BTk_t'(4'b0001)) begin errors++; $display("FAIL nonown_btk got %b want 0001", obtk4[2]); end
    tick;
    full = 1'b0;
    #1;
    checks++; if (gnt4 !== 4'b0001 || we4 !== 1'b1 || obtk4[0].n !== 1'b0) begin errors++; $display("FAIL full_resume got gnt %b we %b n %b want 0001 1 0", gnt4, we4, obtk4[0].n); end
    tick;
    clear_reqs;
    ibtk = '0;
    #1;
    tick;
  endtask

  task automatic test_reset_mid;
    ftk4[0] = '{v: 1'b1, d: 8'h42};
    #1;
    tick;
    for (int w = 0; w < 3; w++) tick;
    #1;
    checks++; if (we4 !== 1'b1) begin errors++; $display("FAIL rmid_4th got %b want 1", we4); end
    reset = 1'b1;
    tick;
    reset = 1'b0;
    #1;
    checks++; if (gnt4 !== 4'b0000 || we4 !== 1'b0 || busy4 !== 1'b0) begin errors++; $display("FAIL rmid_idle got gnt %b we %b busy %b want 0000 0 0", gnt4, we4, busy4); end
    ftk4[1].v = 1'b1;
    ftk4[3].v = 1'b1;
    #1;
    tick;
    #1;
    checks++; if (gnt4 !== 4'b0001) begin errors++; $display("FAIL rmid_first got %b want 0001", gnt4); end
    clear_reqs;
    #1;
    tick; tick;
  endtask

  // NUM_REQ=3, BURST_LEN=1: move pointer to 2, then all request -> 2,0,1,2.
  task automatic test_wrap3;
    int order [4] = '{2, 0, 1, 2};
    logic [2:0] exp;
    ftk3[1].v = 1'b1;
    #1;
    tick;
    #1;
    checks++; if (gnt3 !== 3'b010 || we3 !== 1'b1) begin errors++; $display("FAIL wrap_pre got gnt %b we %b want 010 1", gnt3, we3); end
    ftk3[1].v = 1'b0;
    #1;
    tick;
    for (int i = 0; i < 3; i++) ftk3[i] = '{v: 1'b1, d: 8'(i + 8'hD0)};
    for (int k = 0; k < 4; k++) begin
      #1;
      checks++; if (gnt3 !== 3'b000) begin errors++; $display("FAIL wrap_gap k%0d got %b want 000", k, gnt3); end
      tick;
      #1;
      exp = 3'b001 << order[k];
      checks++; if (gnt3 !== exp || we3 !== 1'b1) begin errors++; $display("FAIL wrap_order k%0d got gnt %b we %b want %b 1", k, gnt3, we3, exp); end
      checks++; if (oftk3.d !== 8'(order[k] + 8'hD0)) begin errors++; $display("FAIL wrap_data got %h want %h", oftk3.d, 8'(order[k] + 8'hD0)); end
      tick;
    end
    clear_reqs;
    #1;
    tick;
  endtask

  task automatic test_read;
    logic [3:0] pat;
    pat = 4'b0101;
    rd_en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      empty = pat[i];
      #1;
      checks++; if (re4 !== ~pat[i] || re3 !== ~pat[i]) begin errors++; $display("FAIL read_re i%0d got %b %b want %b", i, re4, re3, ~pat[i]); end
    end
    rd_en = 1'b0;
    empty = 1'b0;
    #1;
    checks++; if (re4 !== 1'b0) begin errors++; $display("FAIL read_off got %b want 0", re4); end
  endtask

  initial begin
    ibtk  = '0;
    full  = 1'b0;
    empty = 1'b1;
    rd_en = 1'b0;
    clear_reqs;
    test_reset;
    test_nack_idle;
    test_alternate;
    test_drop;
    test_stall;
    test_full_copy;
    test_reset_mid;
    test_wrap3;
    test_read;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
